// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage front end. Holds the fetch PC and a two-line
// buffer (line A = line holding the PC, line B = the following line), fetches
// 256-bit lines from the I-cache, presents one 32-byte window per bundle to
// the extractor and advances the PC by the increment it returns.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned OFFSET_LIMIT = 24
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirectPc_i,
    input  logic         stall_i,
    output logic         icReq_o,
    output logic [26:0]  icLineAddr_o,
    input  logic         icAck_i,
    input  logic [255:0] icLine_i,
    output logic         fsEnable_o,
    output logic [4:0]   fsByteAddr_o,
    output logic [255:0] fsBlock_o,
    input  logic [3:0]   fsNextByteOffset_i,
    output logic [31:0]  pc_o,
    output logic         fault_o
);

    // Offset limit as a 5-bit value so it compares directly with pc[4:0].
    localparam logic [4:0] OFF_LIMIT    = 5'(OFFSET_LIMIT);
    // A straddling window starts at byte 16 of line A.
    localparam logic [4:0] STRADDLE_OFS = 5'd16;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_REQ_A,
        ST_REQ_B,
        ST_ISSUE,
        ST_WAIT,
        ST_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [255:0]   line_a_q, line_a_d;
    logic [255:0]   line_b_q, line_b_d;
    logic [26:0]    tag_a_q, tag_a_d;
    logic [26:0]    tag_b_q, tag_b_d;
    logic           valid_a_q, valid_a_d;
    logic           valid_b_q, valid_b_d;
    logic [26:0]    req_addr_q, req_addr_d;
    logic           fault_q, fault_d;

    // Derived views of the current PC.
    logic [26:0]    pc_line;
    logic [4:0]     pc_off;
    logic [26:0]    pc_next_line;
    logic           straddle;
    logic           hit_a;
    logic           hit_b;
    logic           in_req;
    logic [31:0]    pc_adv;
    logic [26:0]    adv_line;
    logic           issue_fire;
    logic [255:0]   win_straddle;
    logic [255:0]   window;

    assign pc_line      = pc_q[31:5];
    assign pc_off       = pc_q[4:0];
    assign pc_next_line = pc_line + 27'd1;   // wraps 27'h7FFFFFF -> 0
    assign straddle     = (pc_off > OFF_LIMIT);
    assign hit_a        = valid_a_q && (tag_a_q == pc_line);
    assign hit_b        = valid_b_q && (tag_b_q == pc_next_line);
    assign in_req       = (state_q == ST_REQ_A) || (state_q == ST_REQ_B);
    assign pc_adv       = pc_q + {28'd0, fsNextByteOffset_i};
    assign adv_line     = pc_adv[31:5];

    // Straddle window byte lanes: lanes 0..15 take A bytes 16..31,
    // lanes 16..31 take B bytes 0..15.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_win_lane
            if (gi < 16) begin : g_from_a
                assign win_straddle[gi*8 +: 8] = line_a_q[(gi+16)*8 +: 8];
            end else begin : g_from_b
                assign win_straddle[gi*8 +: 8] = line_b_q[(gi-16)*8 +: 8];
            end
        end
    endgenerate

    assign window = straddle ? win_straddle : line_a_q;

    // A redirect in the ISSUE cycle pre-empts the issue it would race with.
    assign issue_fire = (state_q == ST_ISSUE) && !stall_i && !redirect_i;

    // Output drive: window/offset are only presented during the issue pulse.
    always_comb begin
        icReq_o      = in_req;
        icLineAddr_o = req_addr_q;
        fsEnable_o   = issue_fire;
        fsByteAddr_o = 5'd0;
        fsBlock_o    = '0;
        if (issue_fire) begin
            fsByteAddr_o = straddle ? (pc_off - STRADDLE_OFS) : pc_off;
            fsBlock_o    = window;
        end
        pc_o    = pc_q;
        fault_o = fault_q;
    end

    // Next-state logic: line capture, PC advance, buffer promotion, redirect.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        line_a_d   = line_a_q;
        line_b_d   = line_b_q;
        tag_a_d    = tag_a_q;
        tag_b_d    = tag_b_q;
        valid_a_d  = valid_a_q;
        valid_b_d  = valid_b_q;
        req_addr_d = req_addr_q;
        fault_d    = fault_q;

        // An outstanding request always completes into the buffer it was
        // issued for, even if a redirect arrived while it was pending.
        case (state_q)
            ST_REQ_A: begin
                if (icAck_i) begin
                    line_a_d  = icLine_i;
                    tag_a_d   = req_addr_q;
                    valid_a_d = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_REQ_B: begin
                if (icAck_i) begin
                    line_b_d  = icLine_i;
                    tag_b_d   = req_addr_q;
                    valid_b_d = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            default: ;
        endcase

        if (redirect_i) begin
            // New PC wins; a pending request keeps running until acked and
            // FILL then re-evaluates the buffers against the new PC.
            pc_d    = redirectPc_i;
            fault_d = 1'b0;
            if (!in_req) begin
                state_d = ST_FILL;
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (!hit_a) begin
                        req_addr_d = pc_line;
                        state_d    = ST_REQ_A;
                    end else if (straddle && !hit_b) begin
                        req_addr_d = pc_next_line;
                        state_d    = ST_REQ_B;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!stall_i) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fsNextByteOffset_i == 4'd0) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = pc_adv;
                        // Crossing into the prefetched line: promote B to A
                        // so no refetch is needed.
                        if ((adv_line != tag_a_q) && valid_b_q &&
                            (tag_b_q == adv_line)) begin
                            line_a_d  = line_b_q;
                            tag_a_d   = tag_b_q;
                            valid_a_d = 1'b1;
                            valid_b_d = 1'b0;
                        end
                        state_d = ST_FILL;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: ;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_FILL;
            pc_q       <= RESET_PC;
            tag_a_q    <= 27'd0;
            tag_b_q    <= 27'd0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            req_addr_q <= 27'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_a_q    <= tag_a_d;
            tag_b_q    <= tag_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            req_addr_q <= req_addr_d;
            fault_q    <= fault_d;
        end
    end

    // Line data needs no reset: it is only observed behind its valid bit.
    always_ff @(posedge clock_i) begin
        line_a_q <= line_a_d;
        line_b_q <= line_b_d;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer
// against a byte-addressed memory model of the instruction stream.
module tb_fetch_sequencer;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         redirect_i = 1'b0;
    logic [31:0]  redirectPc_i = 32'd0;
    logic         stall_i = 1'b0;
    logic         icReq_o;
    logic [26:0]  icLineAddr_o;
    logic         icAck_i = 1'b0;
    logic [255:0] icLine_i = '0;
    logic         fsEnable_o;
    logic [4:0]   fsByteAddr_o;
    logic [255:0] fsBlock_o;
    logic [3:0]   fsNextByteOffset_i = 4'd0;
    logic [31:0]  pc_o;
    logic         fault_o;

    fetch_sequencer dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .redirect_i         (redirect_i),
        .redirectPc_i       (redirectPc_i),
        .stall_i            (stall_i),
        .icReq_o            (icReq_o),
        .icLineAddr_o       (icLineAddr_o),
        .icAck_i            (icAck_i),
        .icLine_i           (icLine_i),
        .fsEnable_o         (fsEnable_o),
        .fsByteAddr_o       (fsByteAddr_o),
        .fsBlock_o          (fsBlock_o),
        .fsNextByteOffset_i (fsNextByteOffset_i),
        .pc_o               (pc_o),
        .fault_o            (fault_o)
    );

    always #5 clock_i = ~clock_i;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_pc;
    logic [26:0] req_log[$];

    // Memory content: one pseudo-random byte per byte address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[15:8];
    endfunction

    function automatic logic [255:0] mk_line(input logic [26:0] la);
        logic [255:0] l;
        for (int n = 0; n < 32; n++) l[n*8 +: 8] = mem_byte({la, 5'(n)});
        return l;
    endfunction

    // Window start address: line base, or line base + 16 when an 8-byte
    // bundle at pc would run past the end of the line.
    function automatic logic [31:0] win_base(input logic [31:0] pc);
        return {pc[31:5], 5'd0} + ((pc[4:0] > 5'd24) ? 32'd16 : 32'd0);
    endfunction

    function automatic logic [255:0] exp_window(input logic [31:0] pc);
        logic [255:0] w;
        logic [31:0]  b;
        b = win_base(pc);
        for (int k = 0; k < 32; k++) w[k*8 +: 8] = mem_byte(b + 32'(k));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_issue();
        logic [31:0] d;
        d = model_pc - win_base(model_pc);
        chk("byte_addr", 256'(fsByteAddr_o), 256'(d[4:0]));
        chk("window", fsBlock_o, exp_window(model_pc));
    endtask

    // WAIT cycle: present the increment, then check the PC one cycle later.
    task automatic finish_bundle(input logic [3:0] off);
        @(posedge clock_i); #1;
        icAck_i = 1'b0;
        fsNextByteOffset_i = off;
        @(posedge clock_i); #1;
        fsNextByteOffset_i = 4'd0;
        if (off != 4'd0) model_pc = model_pc + 32'(off);
        chk("pc", 256'(pc_o), 256'(model_pc));
        chk("fault", 256'(fault_o), 256'(off == 4'd0));
    endtask

    // One bundle: serve I-cache requests (ack after ack_delay cycles), wait
    // for the issue pulse, check the window, return the increment.
    task automatic do_bundle(input logic [3:0] off, input int ack_delay, input bit rand_stall,
                             output int n_req, output int issue_cyc);
        int          wait_cnt;
        bit          issued;
        bit          have_addr;
        logic [26:0] held;
        wait_cnt = 0; issued = 0; have_addr = 0; held = '0;
        n_req = 0; issue_cyc = 0;
        for (int cyc = 0; cyc < 200 && !issued; cyc++) begin
            @(posedge clock_i); #1;
            icAck_i = 1'b0;
            stall_i = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (icReq_o) begin
                if (!have_addr) begin
                    held = icLineAddr_o;
                    have_addr = 1;
                end else begin
                    chk("req_addr_stable", 256'(icLineAddr_o), 256'(held));
                end
                if (wait_cnt >= ack_delay) begin
                    icAck_i = 1'b1;
                    icLine_i = mk_line(icLineAddr_o);
                    req_log.push_back(icLineAddr_o);
                    n_req++;
                    wait_cnt = 0;
                    have_addr = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clock_i);
            if (stall_i) begin
                chk("stall_blocks_issue", 256'(fsEnable_o), 256'(0));
            end else if (fsEnable_o) begin
                issued = 1;
                issue_cyc = cyc + 1;
                check_issue();
            end
        end
        stall_i = 1'b0;
        if (!issued) begin
            checks++;
            failures++;
            $error("FAIL issue_timeout observed=no_issue expected=issue pc=%0h", model_pc);
        end else begin
            finish_bundle(off);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          ic;
        int          base_idx;
        int          dup;
        logic [31:0] pc_before;
        logic [3:0]  roff;
        bit          ok;

        // Reset state
        model_pc = 32'd0;
        #12;
        chk("rst_icReq", 256'(icReq_o), 256'(0));
        chk("rst_lineAddr", 256'(icLineAddr_o), 256'(0));
        chk("rst_fsEnable", 256'(fsEnable_o), 256'(0));
        chk("rst_byteAddr", 256'(fsByteAddr_o), 256'(0));
        chk("rst_block", fsBlock_o, 256'(0));
        chk("rst_fault", 256'(fault_o), 256'(0));
        chk("rst_pc", 256'(pc_o), 256'(0));
        @(negedge clock_i);
        reset_i = 1'b1;

        // First fetch: request line 0, first bundle at byte 0
        @(posedge clock_i); #1;
        chk("first_req", 256'(icReq_o), 256'(1));
        chk("first_req_addr", 256'(icLineAddr_o), 256'(0));
        do_bundle(4'd8, 0, 0, n, ic);
        chk("first_nreq", 256'(n), 256'(1));
        chk("first_req_line", 256'(req_log[$]), 256'(0));

        // Sequential hits: 3 cycles per bundle, no requests
        do_bundle(4'd7, 0, 0, n, ic);
        chk("seq_nreq", 256'(n), 256'(0));
        chk("seq_issue_cyc", 256'(ic), 256'(1));
        do_bundle(4'd5, 0, 0, n, ic);
        chk("seq_nreq", 256'(n), 256'(0));
        chk("seq_issue_cyc", 256'(ic), 256'(1));
        do_bundle(4'd8, 0, 0, n, ic);
        chk("seq_nreq", 256'(n), 256'(0));

        // pc=28: straddle, fetch line 1 into B
        do_bundle(4'd8, 1, 0, n, ic);
        chk("straddle_nreq", 256'(n), 256'(1));
        chk("straddle_req_line", 256'(req_log[$]), 256'(1));

        // pc=36: B promoted, no new request
        do_bundle(4'd4, 0, 0, n, ic);
        chk("promote_nreq", 256'(n), 256'(0));
        chk("promote_issue_cyc", 256'(ic), 256'(1));

        // Stall held 5 cycles in ISSUE at pc=40
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock_i); #1;
            @(negedge clock_i);
            chk("stall_hold", 256'(fsEnable_o), 256'(0));
        end
        @(posedge clock_i); #1;
        stall_i = 1'b0;
        @(negedge clock_i);
        chk("issue_after_stall", 256'(fsEnable_o), 256'(1));
        if (fsEnable_o) check_issue();
        finish_bundle(4'd6);

        // Offset 0 at pc=46: fault, everything quiet
        do_bundle(4'd0, 0, 0, n, ic);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock_i); #1;
            chk("fault_no_req", 256'(icReq_o), 256'(0));
            chk("fault_held", 256'(fault_o), 256'(1));
            @(negedge clock_i);
            chk("fault_no_issue", 256'(fsEnable_o), 256'(0));
        end
        @(posedge clock_i); #1;
        redirect_i = 1'b1;
        redirectPc_i = 32'h100;
        @(posedge clock_i); #1;
        redirect_i = 1'b0;
        model_pc = 32'h100;
        chk("redir_pc", 256'(pc_o), 256'(model_pc));
        chk("redir_fault_clr", 256'(fault_o), 256'(0));
        @(posedge clock_i); #1;
        chk("redir_req", 256'(icReq_o), 256'(1));
        chk("redir_req_addr", 256'(icLineAddr_o), 256'(8));

        // Redirect to 0x200 while line 8 is outstanding; ack 3 cycles later
        redirect_i = 1'b1;
        redirectPc_i = 32'h200;
        @(posedge clock_i); #1;
        redirect_i = 1'b0;
        model_pc = 32'h200;
        chk("redir2_pc", 256'(pc_o), 256'(model_pc));
        for (int i = 0; i < 3; i++) begin
            chk("held_req", 256'(icReq_o), 256'(1));
            chk("held_addr", 256'(icLineAddr_o), 256'(8));
            if (i < 2) begin
                @(posedge clock_i); #1;
            end
        end
        icAck_i = 1'b1;
        icLine_i = mk_line(27'd8);
        @(posedge clock_i); #1;
        icAck_i = 1'b0;
        chk("req_drop_after_ack", 256'(icReq_o), 256'(0));
        @(posedge clock_i); #1;
        chk("refetch_req", 256'(icReq_o), 256'(1));
        chk("refetch_addr", 256'(icLineAddr_o), 256'(16));
        do_bundle(4'd8, 0, 0, n, ic);
        chk("refetch_nreq", 256'(n), 256'(1));

        // Asynchronous reset in the middle of a request
        redirect_i = 1'b1;
        redirectPc_i = 32'h400;
        @(posedge clock_i); #1;
        redirect_i = 1'b0;
        @(posedge clock_i); #1;
        chk("pre_rst_req", 256'(icReq_o), 256'(1));
        chk("pre_rst_addr", 256'(icLineAddr_o), 256'(32));
        #2;
        reset_i = 1'b0;
        #1;
        chk("async_rst_req", 256'(icReq_o), 256'(0));
        chk("async_rst_pc", 256'(pc_o), 256'(0));
        chk("async_rst_addr", 256'(icLineAddr_o), 256'(0));
        @(negedge clock_i);
        reset_i = 1'b1;
        model_pc = 32'd0;

        // Redirect coinciding with ack, to 0xFFFF_FFFC: line+1 wraps to 0
        @(posedge clock_i); #1;
        chk("rst2_req", 256'(icReq_o), 256'(1));
        redirect_i = 1'b1;
        redirectPc_i = 32'hFFFF_FFFC;
        icAck_i = 1'b1;
        icLine_i = mk_line(27'd0);
        @(posedge clock_i); #1;
        redirect_i = 1'b0;
        icAck_i = 1'b0;
        model_pc = 32'hFFFF_FFFC;
        chk("wrap_pc", 256'(pc_o), 256'(model_pc));
        chk("wrap_fill_noreq", 256'(icReq_o), 256'(0));
        req_log.delete();
        do_bundle(4'd8, 2, 0, n, ic);
        chk("wrap_nreq", 256'(n), 256'(2));
        if (req_log.size() == 2) begin
            chk("wrap_req_a", 256'(req_log[0]), 256'(27'h7FF_FFFF));
            chk("wrap_req_b", 256'(req_log[1]), 256'(0));
        end
        do_bundle(4'd3, 0, 0, n, ic);
        chk("wrap_promote_nreq", 256'(n), 256'(0));

        // Randomized straight-line run with random ack delays and stalls
        req_log.delete();
        for (int t = 0; t < 40; t++) begin
            pc_before = model_pc;
            base_idx = req_log.size();
            roff = 4'($urandom_range(1, 15));
            do_bundle(roff, $urandom_range(0, 3), 1, n, ic);
            for (int r = base_idx; r < req_log.size(); r++) begin
                ok = (req_log[r] == pc_before[31:5]) ||
                     ((req_log[r] == pc_before[31:5] + 27'd1) && (pc_before[4:0] > 5'd24));
                chk("rand_req_line", 256'(ok), 256'(1));
                dup = 0;
                for (int s = 0; s < req_log.size(); s++)
                    if (req_log[s] == req_log[r]) dup++;
                chk("rand_req_once", 256'(dup), 256'(1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
